// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state encoding, funct3 codes and op checks for the load/store unit
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr);
    return (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && addr != 2'b00);
  endfunction
  function automatic logic is_legal(input logic is_load, input logic [2:0] funct3);
    return is_load ? (funct3 == F3_B || funct3 == F3_H || funct3 == F3_W || funct3 == F3_BU || funct3 == F3_HU)
                   : (funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane steering for stores and lane select plus extension for loads
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o
);
  logic [31:0] sh;
  logic        sext;
  // replicate store data across lanes and pick strobes; select and extend the load lane
  always_comb begin
    sh      = rdata_i >> {addr_i, 3'b000};
    sext    = ~funct3_i[2];
    wstrb_o = funct3_i == F3_B ? 4'b0001 << addr_i :
              funct3_i == F3_H ? 4'b0011 << addr_i :
              funct3_i == F3_W ? 4'b1111 : 4'b0000;
    wdata_o = funct3_i[1:0] == 2'b00 ? {4{wdata_i[7:0]}} :
              funct3_i[1:0] == 2'b01 ? {2{wdata_i[15:0]}} : wdata_i;
    ldata_o = funct3_i[1:0] == 2'b00 ? {{24{sext & sh[7]}}, sh[7:0]} :
              funct3_i[1:0] == 2'b01 ? {{16{sext & sh[15]}}, sh[15:0]} : rdata_i;
  end
endmodule

// File: rtl/lsu.sv
// lsu: multi-cycle load/store unit bridging execute to data memory and register writeback
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_is_load,
  input  logic        ex_is_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wstrb,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata,
  output logic [4:0]  gpr_waddr,
  output logic [31:0] gpr_wdata,
  output logic        gpr_wen,
  output logic        lsu_done,
  output logic        lsu_err,
  output logic        busy
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [31:0]      addr_q, wdata_q, rdata_q;
  logic [2:0]       f3_q;
  logic [4:0]       rd_q;
  logic             load_q;
  logic             accept, bad, tmo, in_req, in_done, st_req;
  logic [3:0]       strb;
  logic [31:0]      wsh, ldata;

  lsu_align u_align (
    .funct3_i (f3_q),
    .addr_i   (addr_q[1:0]),
    .wdata_i  (wdata_q),
    .rdata_i  (mem_resp_rdata),
    .wstrb_o  (strb),
    .wdata_o  (wsh),
    .ldata_o  (ldata)
  );

  assign accept = state_q == IDLE && ex_valid && (ex_is_load || ex_is_store);
  assign bad    = (ex_is_load && ex_is_store) || !is_legal(ex_is_load, ex_funct3) || is_misaligned(ex_funct3, ex_addr[1:0]);
  // the timeout fires on the cycle that would bring the count up to the limit
  assign tmo    = TIMEOUT_CYCLES != 0 && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);

  // next-state: faulty ops skip memory, timeouts take priority over late handshakes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = bad ? DONE : REQ;
        err_d   = bad;
        cnt_d   = '0;
      end
      REQ: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = tmo ? DONE : mem_req_ready ? RESP : REQ;
        err_d   = tmo;
      end
      RESP: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = tmo ? DONE : mem_resp_valid ? DONE : RESP;
        err_d   = tmo;
      end
      default: state_d = IDLE;
    endcase
  end

  // state, counter and latched op; reset drops any in-flight access
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (accept) begin
        addr_q  <= ex_addr;
        wdata_q <= ex_wdata;
        f3_q    <= ex_funct3;
        rd_q    <= ex_rd;
        load_q  <= ex_is_load;
      end
      if (state_q == RESP && mem_resp_valid) rdata_q <= ldata;
    end
  end

  assign in_req        = state_q == REQ;
  assign in_done       = state_q == DONE;
  assign st_req        = in_req && !load_q;
  assign busy          = state_q != IDLE;
  assign ex_ready      = !busy;
  assign mem_req_valid = in_req;
  assign mem_req_addr  = in_req ? {addr_q[31:2], 2'b00} : '0;
  assign mem_req_wen   = st_req;
  assign mem_req_wdata = st_req ? wsh : '0;
  assign mem_req_wstrb = st_req ? strb : '0;
  assign lsu_done      = in_done;
  assign lsu_err       = in_done && err_q;
  assign gpr_wen       = in_done && !err_q && load_q && rd_q != 5'd0;
  assign gpr_waddr     = in_done ? rd_q : '0;
  assign gpr_wdata     = in_done && !err_q && load_q ? rdata_q : '0;
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: randomized and directed checks of the load/store unit against a behavioural model
module tb_lsu;
  logic        sys_clk = 1'b0, sys_rst = 1'b1;
  logic        ex_valid = 1'b0, ex_ready, ex_is_load = 1'b0, ex_is_store = 1'b0;
  logic [2:0]  ex_funct3 = '0;
  logic [31:0] ex_addr = '0, ex_wdata = '0;
  logic [4:0]  ex_rd = '0;
  logic        mem_req_valid, mem_req_ready = 1'b0, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_rdata = '0;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic        gpr_wen, lsu_done, lsu_err, busy;
  int          checks = 0, failures = 0;

  lsu #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata), .gpr_wen(gpr_wen),
    .lsu_done(lsu_done), .lsu_err(lsu_err), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive_op(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [4:0] rd);
    ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st;
    ex_funct3 = f3; ex_addr = addr; ex_wdata = wd; ex_rd = rd;
  endtask

  task automatic run_op(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] rdata,
                        input int rw, input int sw);
    logic        legal, err, exp_wen;
    logic [31:0] sh, b, h, exp_ld, exp_wd;
    logic [3:0]  exp_st;
    int          lat, cyc, rc, sc, nreq;
    logic        hs, in_resp;
    legal   = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
    err     = (ld && st) || !legal || (addr % (32'd1 << f3[1:0]) != 0);
    sh      = rdata >> (8 * addr[1:0]);
    b       = sh & 32'hFF;
    h       = sh & 32'hFFFF;
    exp_ld  = f3 == 3'd0 ? (b[7] ? b | 32'hFFFFFF00 : b) :
              f3 == 3'd1 ? (h[15] ? h | 32'hFFFF0000 : h) :
              f3 == 3'd4 ? b : f3 == 3'd5 ? h : rdata;
    exp_st  = f3 == 3'd0 ? 4'b0001 << addr[1:0] : f3 == 3'd1 ? 4'b0011 << addr[1:0] : 4'b1111;
    exp_wd  = f3 == 3'd0 ? (wd & 32'hFF) * 32'h01010101 :
              f3 == 3'd1 ? (wd & 32'hFFFF) * 32'h00010001 : wd;
    exp_wen = ld && !err && rd != 5'd0;
    lat     = err ? 1 : 3 + rw + sw;
    drive_op(ld, st, f3, addr, wd, rd);
    chk("ex_ready", ex_ready, 1);
    @(negedge sys_clk);
    ex_valid = 1'b0;
    cyc = 1; rc = 0; sc = 0; nreq = 0; hs = 1'b0; in_resp = 1'b0;
    while (!lsu_done && cyc <= 20) begin
      if (mem_req_valid) begin
        nreq++;
        chk("req_addr", mem_req_addr, addr & ~32'h3);
        chk("req_wen", mem_req_wen, st);
        chk("req_wstrb", mem_req_wstrb, st ? exp_st : 4'b0000);
        if (st) chk("req_wdata", mem_req_wdata, exp_wd);
        mem_req_ready  = rc == rw;
        hs             = hs || mem_req_ready;
        rc++;
        mem_resp_valid = 1'($urandom_range(0, 1));
        mem_resp_rdata = $urandom;
      end else if (in_resp) begin
        mem_resp_valid = sc == sw;
        mem_resp_rdata = mem_resp_valid ? rdata : $urandom;
        sc++;
      end
      @(negedge sys_clk);
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
      in_resp = hs;
      cyc++;
    end
    chk("done_seen", lsu_done, 1);
    chk("latency", cyc, lat);
    chk("err", lsu_err, err);
    chk("gpr_wen", gpr_wen, exp_wen);
    if (exp_wen) begin
      chk("gpr_waddr", gpr_waddr, rd);
      chk("gpr_wdata", gpr_wdata, exp_ld);
    end
    chk("nreq", nreq, err ? 0 : rw + 1);
    @(negedge sys_clk);
    chk("busy_after", busy, 0);
    chk("done_pulse", lsu_done, 0);
  endtask

  initial begin
    int cyc;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_ready", ex_ready, 1);
    chk("rst_reqv", mem_req_valid, 0);
    chk("rst_done", lsu_done, 0);
    chk("rst_gwen", gpr_wen, 0);
    chk("rst_gdata", gpr_wdata, 0);
    chk("rst_err", lsu_err, 0);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    run_op(1, 0, 3'b010, 32'h80000100, 32'h0, 5'd5, 32'hDEADBEEF, 0, 0);
    run_op(1, 0, 3'b000, 32'h80000103, 32'h0, 5'd6, 32'h80FF0000, 0, 0);
    run_op(1, 0, 3'b100, 32'h80000103, 32'h0, 5'd6, 32'h80FF0000, 0, 0);
    run_op(1, 0, 3'b001, 32'h80000102, 32'h0, 5'd7, 32'h80FF0000, 0, 0);
    run_op(0, 1, 3'b001, 32'h80000102, 32'h1234ABCD, 5'd3, 32'h0, 3, 0);
    run_op(1, 0, 3'b010, 32'h80000101, 32'h0, 5'd4, 32'h0, 0, 0);
    run_op(1, 0, 3'b011, 32'h80000100, 32'h0, 5'd4, 32'h0, 0, 0);
    run_op(1, 1, 3'b010, 32'h80000100, 32'h0, 5'd4, 32'h0, 0, 0);
    run_op(1, 0, 3'b010, 32'h80000200, 32'h0, 5'd0, 32'h11223344, 1, 1);
    drive_op(0, 0, 3'b010, 32'h100, 32'h0, 5'd1);
    @(negedge sys_clk);
    ex_valid = 1'b0;
    chk("neither_ignored", busy, 0);
    drive_op(1, 0, 3'b010, 32'h80000300, 32'h0, 5'd9);
    @(negedge sys_clk);
    ex_valid = 1'b0;
    cyc = 1;
    while (!lsu_done && cyc <= 20) begin
      @(negedge sys_clk);
      cyc++;
    end
    chk("tmo_lat", cyc, 9);
    chk("tmo_err", lsu_err, 1);
    chk("tmo_gwen", gpr_wen, 0);
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hCAFEF00D;
    @(negedge sys_clk);
    mem_resp_valid = 1'b0;
    chk("late_resp_busy", busy, 0);
    chk("late_resp_gwen", gpr_wen, 0);
    run_op(1, 0, 3'b010, 32'h80000304, 32'h0, 5'd9, 32'h5A5A1234, 0, 0);
    drive_op(1, 0, 3'b010, 32'h80000400, 32'h0, 5'd8);
    @(negedge sys_clk);
    ex_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge sys_clk);
    mem_req_ready = 1'b0;
    chk("resp_busy", busy, 1);
    sys_rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_reqv", mem_req_valid, 0);
    chk("mid_rst_gwen", gpr_wen, 0);
    chk("mid_rst_done", lsu_done, 0);
    chk("mid_rst_ready", ex_ready, 1);
    @(negedge sys_clk);
    sys_rst = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h01020304;
    @(negedge sys_clk);
    mem_resp_valid = 1'b0;
    chk("post_rst_gwen", gpr_wen, 0);
    chk("post_rst_busy", busy, 0);
    for (int i = 0; i < 60; i++) begin
      logic ld, st;
      int   kind;
      kind = $urandom_range(0, 9);
      ld   = kind == 9 ? 1'b1 : kind < 5;
      st   = kind == 9 ? 1'b1 : kind >= 5;
      run_op(ld, st, 3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom_range(0, 31)), $urandom,
             $urandom_range(0, 2), $urandom_range(0, 2));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Multi-cycle load/store unit between the execute stage and the writeback/register-file stage.
- Accepts one memory operation at a time from execute and drives a valid/ready request channel to data memory.
- Waits for the response. For loads, aligns and extends the data and issues a one-cycle register write (gpr_waddr/gpr_wdata/gpr_wen) to writeback.
- busy is used by the core to hold the PC and upstream stages.

Parameters:
- TIMEOUT_CYCLES, 256: cycles allowed in REQ+RESP before an access fault is raised; 0 disables the timeout.
- CNT_W, 16: width of the timeout counter; must satisfy TIMEOUT_CYCLES < 2**CNT_W.

Ports:
- sys_clk  in  1  clock
- sys_rst  in  1  reset
- ex_valid  in  1  execute presents a memory op
- ex_ready  out  1  LSU can accept an op
- ex_is_load  in  1  op is a load
- ex_is_store  in  1  op is a store
- ex_funct3  in  3  RV size/sign field
- ex_addr  in  32  effective address
- ex_wdata  in  32  store source (rs2)
- ex_rd  in  5  load destination register
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  32  word-aligned address (addr[1:0]=0)
- mem_req_wen  out  1  1=store, 0=load
- mem_req_wdata  out  32  lane-shifted store data
- mem_req_wstrb  out  4  byte strobes (0 for loads)
- mem_resp_valid  in  1  response valid
- mem_resp_rdata  in  32  load word
- gpr_waddr  out  5  writeback register index
- gpr_wdata  out  32  aligned/extended load data
- gpr_wen  out  1  one-cycle write strobe
- lsu_done  out  1  one-cycle completion pulse
- lsu_err  out  1  one-cycle fault pulse (with lsu_done)
- busy  out  1  state != IDLE

Behaviour:
- Reset (sys_rst asynchronous, active-high; clock sys_clk): state=IDLE; the timeout counter and all registered outputs are 0, including gpr_*, lsu_done, lsu_err, mem_req_*. ex_ready is 1 after reset.
- States: IDLE, REQ, RESP, DONE.
- IDLE:
  - ex_ready=1.
  - On ex_valid & (ex_is_load ^ ex_is_store), latch addr, wdata, funct3, rd and op type.
  - Legal and aligned op: go to REQ.
  - Illegal or misaligned op: go to DONE with err set; no memory request.
  - ex_valid with neither op flag set: ignored.
  - ex_valid with both op flags set: go to DONE with err set.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other value is illegal.
- Misaligned: half access with addr[0]=1; word access with addr[1:0]!=0.
- REQ:
  - mem_req_valid=1 and all mem_req_* fields held stable until the cycle with mem_req_ready=1.
  - On that handshake, go to RESP.
- Store encoding:
  - wstrb: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111.
  - wdata: byte replicated x4 for SB, half replicated x2 for SH, full word for SW.
- RESP:
  - mem_resp_valid is sampled only in this state; a response in any other state is ignored.
  - On response, go to DONE.
  - For a load, compute gpr_wdata by selecting the lane addr[1:0] and sign-extending (LB/LH) or zero-extending (LBU/LHU).
- DONE (exactly 1 cycle, then IDLE):
  - lsu_done=1; lsu_err as latched.
  - gpr_wen=1 only for a successful load with rd!=0.
  - gpr_waddr=rd; gpr_wdata is valid only in this cycle.
- Timeout:
  - The counter clears on entry to REQ and increments each cycle in REQ or RESP.
  - When it reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0), go to DONE with err=1 and gpr_wen=0.
  - A late response after a timeout is ignored.
- Latency: with zero-wait memory (req_ready=1 in REQ, resp_valid the next cycle), an op accepted at cycle T has DONE at T+3. An illegal or misaligned op has DONE at T+1.
- busy=1 from the cycle after acceptance through DONE inclusive. ex_ready=!busy.
- Reset mid-operation: immediate return to IDLE; the in-flight request is dropped and no gpr_wen is issued.

Decomposition:
- lsu_pkg:
  - state enum (IDLE/REQ/RESP/DONE)
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU
  - helper function is_misaligned(funct3, addr)
- Sub-module lsu_align (combinational):
  - Inputs funct3, addr[1:0], store data, load word.
  - Outputs wstrb, lane-shifted wdata, extended load data.
- The FSM, counter and output registers stay in lsu.

Test Plan:
- LW at 0x80000100; memory returns 0xDEADBEEF with zero wait; rd=5 -> gpr_wen=1 at T+3, gpr_waddr=5, gpr_wdata=0xDEADBEEF, lsu_err=0.
- LB at addr 0x...103; rdata=0x80FF_0000 -> gpr_wdata=0xFFFFFF80. LBU at the same addr -> 0x00000080. LH at addr ...102 -> 0xFFFF80FF.
- SH at 0x...102, wdata=0x1234ABCD -> mem_req_wstrb=4'b1100, mem_req_wdata=0xABCDABCD, mem_req_wen=1; mem_req_ready held 0 for 3 cycles -> request fields stable; done with gpr_wen=0.
- LW at 0x...101 -> no mem_req_valid ever; DONE at T+1 with lsu_err=1, gpr_wen=0. funct3=011 load -> same result.
- TIMEOUT_CYCLES=8 with mem_req_ready stuck at 0 -> lsu_err and lsu_done pulse after 8 cycles in REQ. A later mem_resp_valid is ignored; the next op is accepted normally.
- Load with rd=0 -> lsu_done=1, gpr_wen=0. Assert sys_rst while in RESP -> state IDLE, busy=0 and all outputs 0 immediately; no write occurs.
